// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the DDC control link: header bytes, frame layout, field bundle,
// FSM states and byte-selection helpers used by both encoder and decoder.
package ctrl_link_pkg;

    localparam logic [7:0] HDR1 = 8'hAA;
    localparam logic [7:0] HDR2 = 8'h55;
    localparam int unsigned NBYTES = 22;
    localparam int unsigned BIT_CLKS = 4;

    // 1-based byte positions within the frame
    localparam logic [4:0] IDX_HDR1       = 5'd1;
    localparam logic [4:0] IDX_HDR2       = 5'd2;
    localparam logic [4:0] IDX_WORK_MODE  = 5'd3;
    localparam logic [4:0] IDX_VER_CODE   = 5'd4;
    localparam logic [4:0] IDX_WAVE_CODE  = 5'd5;
    localparam logic [4:0] IDX_FRE_CODE   = 5'd6;
    localparam logic [4:0] IDX_PRI_LO     = 5'd7;
    localparam logic [4:0] IDX_PRI_HI     = 5'd8;
    localparam logic [4:0] IDX_HOR1       = 5'd9;
    localparam logic [4:0] IDX_HOR2       = 5'd10;
    localparam logic [4:0] IDX_HOR3       = 5'd11;
    localparam logic [4:0] IDX_PULSE_MODE = 5'd12;
    localparam logic [4:0] IDX_MON_ADDR   = 5'd13;
    localparam logic [4:0] IDX_MON_MODE   = 5'd14;
    localparam logic [4:0] IDX_HPR_LO     = 5'd15;
    localparam logic [4:0] IDX_HPR_HI     = 5'd16;
    localparam logic [4:0] IDX_VPR_LO     = 5'd17;
    localparam logic [4:0] IDX_VPR_HI     = 5'd18;
    localparam logic [4:0] IDX_HPT_LO     = 5'd19;
    localparam logic [4:0] IDX_HPT_HI     = 5'd20;
    localparam logic [4:0] IDX_VPT_LO     = 5'd21;
    localparam logic [4:0] IDX_VPT_HI     = 5'd22;
    localparam logic [4:0] IDX_CHKSUM     = 5'd23;

    typedef enum logic [1:0] {StIdle, StSync, StShift, StGap} ctrl_state_e;

    typedef struct packed {
        logic [7:0]  work_mode;
        logic [7:0]  ver_code;
        logic [7:0]  wave_code;
        logic [7:0]  fre_code;
        logic [15:0] pri_code;
        logic [7:0]  hor1_code;
        logic [7:0]  hor2_code;
        logic [7:0]  hor3_code;
        logic [7:0]  pulse_mode;
        logic [7:0]  monitor_addr;
        logic [7:0]  monitor_mode;
        logic [15:0] hor_phase_r;
        logic [15:0] ver_phase_r;
        logic [15:0] hor_phase_t;
        logic [15:0] ver_phase_t;
    } ctrl_fields_t;

    function automatic logic [7:0] field_byte(ctrl_fields_t f, logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            IDX_HDR1:       b = HDR1;
            IDX_HDR2:       b = HDR2;
            IDX_WORK_MODE:  b = f.work_mode;
            IDX_VER_CODE:   b = f.ver_code;
            IDX_WAVE_CODE:  b = f.wave_code;
            IDX_FRE_CODE:   b = f.fre_code;
            IDX_PRI_LO:     b = f.pri_code[7:0];
            IDX_PRI_HI:     b = f.pri_code[15:8];
            IDX_HOR1:       b = f.hor1_code;
            IDX_HOR2:       b = f.hor2_code;
            IDX_HOR3:       b = f.hor3_code;
            IDX_PULSE_MODE: b = f.pulse_mode;
            IDX_MON_ADDR:   b = f.monitor_addr;
            IDX_MON_MODE:   b = f.monitor_mode;
            IDX_HPR_LO:     b = f.hor_phase_r[7:0];
            IDX_HPR_HI:     b = f.hor_phase_r[15:8];
            IDX_VPR_LO:     b = f.ver_phase_r[7:0];
            IDX_VPR_HI:     b = f.ver_phase_r[15:8];
            IDX_HPT_LO:     b = f.hor_phase_t[7:0];
            IDX_HPT_HI:     b = f.hor_phase_t[15:8];
            IDX_VPT_LO:     b = f.ver_phase_t[7:0];
            IDX_VPT_HI:     b = f.ver_phase_t[15:8];
            default:        b = 8'h00;
        endcase
        return b;
    endfunction

    // XOR of the payload bytes (headers excluded)
    function automatic logic [7:0] frame_xor(ctrl_fields_t f);
        logic [7:0] x;
        x = 8'h00;
        for (int i = int'(IDX_WORK_MODE); i <= int'(IDX_VPT_HI); i++) begin
            x = x ^ field_byte(f, 5'(i));
        end
        return x;
    endfunction

endpackage

// File: rtl/ctrl_byte_ser.sv
// 8-bit PISO: loads a byte, shifts it out MSB first at BIT_CLKS cycles per bit and
// pulses byte_done in the last cycle of bit 7. Output is a flop that shifts to 0 when done.
module ctrl_byte_ser
    import ctrl_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       sdata,
    output logic       byte_done
);

    logic [7:0] shreg_q;
    logic [1:0] clk_cnt_q;
    logic [2:0] bit_cnt_q;
    logic       active_q;

    assign sdata     = shreg_q[7];
    assign byte_done = active_q && (clk_cnt_q == 2'(BIT_CLKS - 1)) && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= 8'h00;
            clk_cnt_q <= 2'd0;
            bit_cnt_q <= 3'd0;
            active_q  <= 1'b0;
        end else if (load) begin
            shreg_q   <= din;
            clk_cnt_q <= 2'd0;
            bit_cnt_q <= 3'd0;
            active_q  <= 1'b1;
        end else if (active_q) begin
            if (clk_cnt_q == 2'(BIT_CLKS - 1)) begin
                clk_cnt_q <= 2'd0;
                shreg_q   <= {shreg_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    active_q <= 1'b0;
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ctrl_encode.sv
// DDC control-frame encoder: staging, per-frame snapshot, FSM and period timing.
// Define CTRL_ENC_CHKSUM_EN to append a 23rd XOR checksum byte to every frame.
module ctrl_encode
    import ctrl_link_pkg::*;
#(
    parameter int unsigned FPRI_WIDTH   = 100,
    parameter int unsigned FRAME_PERIOD = 10000
) (
    input  logic        glb_100M,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [7:0]  work_mode,
    input  logic [7:0]  ver_code,
    input  logic [7:0]  wave_code,
    input  logic [7:0]  fre_code,
    input  logic [7:0]  hor1_code,
    input  logic [7:0]  hor2_code,
    input  logic [7:0]  hor3_code,
    input  logic [7:0]  pulse_mode,
    input  logic [7:0]  monitor_addr,
    input  logic [7:0]  monitor_mode,
    input  logic [15:0] pri_code,
    input  logic [15:0] hor_phase_R,
    input  logic [15:0] ver_phase_R,
    input  logic [15:0] hor_phase_T,
    input  logic [15:0] ver_phase_T,
    output logic        FPRI,
    output logic        code,
    output logic        busy,
    output logic        frame_done
);

`ifdef CTRL_ENC_CHKSUM_EN
    localparam logic [4:0] LAST_IDX = IDX_CHKSUM;
`else
    localparam logic [4:0] LAST_IDX = IDX_VPT_HI;
`endif

    ctrl_state_e  state_q, state_d;
    ctrl_fields_t stage_q, frame_q, fields_in;
    logic [15:0]  period_q, period_d;
    logic [15:0]  sync_cnt_q, sync_cnt_d;
    logic [4:0]   idx_q, idx_d;
    logic         fpri_q, fpri_d, busy_q, busy_d, done_q, done_d;
    logic         snap, ser_load, byte_done;
    logic [7:0]   ser_din;

    assign fields_in = '{work_mode: work_mode, ver_code: ver_code, wave_code: wave_code,
                         fre_code: fre_code, pri_code: pri_code, hor1_code: hor1_code,
                         hor2_code: hor2_code, hor3_code: hor3_code, pulse_mode: pulse_mode,
                         monitor_addr: monitor_addr, monitor_mode: monitor_mode,
                         hor_phase_r: hor_phase_R, ver_phase_r: ver_phase_R,
                         hor_phase_t: hor_phase_T, ver_phase_t: ver_phase_T};

    assign FPRI       = fpri_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_comb begin
        ser_din = field_byte(frame_q, idx_q);
`ifdef CTRL_ENC_CHKSUM_EN
        if (idx_q == IDX_CHKSUM) ser_din = frame_xor(frame_q);
`endif
    end

    always_comb begin
        state_d    = state_q;
        fpri_d     = fpri_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        sync_cnt_d = sync_cnt_q;
        snap       = 1'b0;
        ser_load   = 1'b0;
        period_d   = (period_q == 16'hFFFF) ? period_q : period_q + 16'd1;

        // A frame start is shared by IDLE and the end of GAP
        if ((state_q == StIdle && enable) ||
            (state_q == StGap && period_q == 16'(FRAME_PERIOD - 1) && enable)) begin
            state_d    = StSync;
            fpri_d     = 1'b1;
            busy_d     = 1'b1;
            snap       = 1'b1;
            period_d   = 16'd0;
            sync_cnt_d = 16'd0;
            idx_d      = IDX_HDR1;
        end else begin
            case (state_q)
                StSync: begin
                    if (sync_cnt_q == 16'(FPRI_WIDTH - 1)) begin
                        state_d  = StShift;
                        fpri_d   = 1'b0;
                        ser_load = 1'b1;
                        idx_d    = idx_q + 5'd1;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 16'd1;
                    end
                end
                StShift: begin
                    if (byte_done) begin
                        if (idx_q > LAST_IDX) begin
                            state_d = StGap;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            ser_load = 1'b1;
                            idx_d    = idx_q + 5'd1;
                        end
                    end
                end
                StGap: begin
                    if (period_q == 16'(FRAME_PERIOD - 1)) state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge glb_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            stage_q    <= '0;
            frame_q    <= '0;
            period_q   <= 16'd0;
            sync_cnt_q <= 16'd0;
            idx_q      <= 5'd0;
            fpri_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            sync_cnt_q <= sync_cnt_d;
            idx_q      <= idx_d;
            fpri_q     <= fpri_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            if (cfg_load) stage_q <= fields_in;
            // Snapshot sees the pre-load staging value, so a same-edge load lands next frame
            if (snap) frame_q <= stage_q;
        end
    end

    ctrl_byte_ser u_ser (
        .clk       (glb_100M),
        .rst_n     (rst_n),
        .load      (ser_load),
        .din       (ser_din),
        .sdata     (code),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_ctrl_encode.sv
// Self-checking bench for ctrl_encode: randomised fields against a byte-list frame model.
// Honours CTRL_ENC_CHKSUM_EN for the expected frame length and checksum byte.
module tb_ctrl_encode;

    localparam int FW = 100;
    localparam int FP = 3000;
`ifdef CTRL_ENC_CHKSUM_EN
    localparam int NBT = 23;
`else
    localparam int NBT = 22;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic cfg_load = 1'b0;
    logic [7:0] in_b [3:22];
    logic [7:0] st_b [3:22];
    logic [7:0] got_b [1:23];
    logic fpri, code, busy, frame_done;
    int checks = 0;
    int failures = 0;
    bit cap_ok, cap_code_bad, cap_seq_bad, cap_done_ok;
    int cap_width;

    always #5 clk = ~clk;

    ctrl_encode #(.FPRI_WIDTH(FW), .FRAME_PERIOD(FP)) dut (
        .glb_100M(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
        .work_mode(in_b[3]), .ver_code(in_b[4]), .wave_code(in_b[5]), .fre_code(in_b[6]),
        .pri_code({in_b[8], in_b[7]}), .hor1_code(in_b[9]), .hor2_code(in_b[10]),
        .hor3_code(in_b[11]), .pulse_mode(in_b[12]), .monitor_addr(in_b[13]),
        .monitor_mode(in_b[14]), .hor_phase_R({in_b[16], in_b[15]}),
        .ver_phase_R({in_b[18], in_b[17]}), .hor_phase_T({in_b[20], in_b[19]}),
        .ver_phase_T({in_b[22], in_b[21]}), .FPRI(fpri), .code(code), .busy(busy),
        .frame_done(frame_done)
    );

    // Expected frame byte i (1-based) from the modelled staging contents
    function automatic logic [7:0] exp_byte(int i);
        logic [7:0] x;
        if (i == 1) return 8'hAA;
        if (i == 2) return 8'h55;
        if (i <= 22) return st_b[i];
        x = 8'h00;
        for (int j = 3; j <= 22; j++) x = x ^ st_b[j];
        return x;
    endfunction

    task automatic do_load();
        @(negedge clk);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        for (int i = 3; i <= 22; i++) st_b[i] = in_b[i];
    endtask

    // Waits for FPRI, measures its width, then samples every bit cycle of the frame.
    // Returns positioned on the cycle where frame_done is expected.
    task automatic cap_frame(input int drop_bit);
        int w;
        logic b;
        cap_ok = 1'b1; cap_width = 0; cap_code_bad = 1'b0; cap_seq_bad = 1'b0;
        cap_done_ok = 1'b0;
        w = 0;
        while (fpri !== 1'b1 && w < FP + 10) begin @(negedge clk); w++; end
        if (fpri !== 1'b1) begin cap_ok = 1'b0; return; end
        while (fpri === 1'b1 && cap_width < FP) begin cap_width++; @(negedge clk); end
        for (int n = 0; n < NBT * 8; n++) begin
            b = code;
            for (int c = 0; c < 4; c++) begin
                if (n == drop_bit && c == 0) enable = 1'b0;
                if (code !== b) cap_code_bad = 1'b1;
                if (busy !== 1'b1 || frame_done !== 1'b0 || fpri !== 1'b0) cap_seq_bad = 1'b1;
                @(negedge clk);
            end
            got_b[n / 8 + 1] = {got_b[n / 8 + 1][6:0], b};
        end
        cap_done_ok = (frame_done === 1'b1) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 3; i <= 22; i++) begin in_b[i] = 8'h00; st_b[i] = 8'h00; end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fpri !== 1'b0) begin failures++; $display("FAIL reset_fpri got=%b exp=0", fpri); end
        checks++; if (code !== 1'b0) begin failures++; $display("FAIL reset_code got=%b exp=0", code); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (fpri !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_frame got=%b%b exp=00", fpri, busy); end
    endtask

    task automatic test_default_frame();
        enable = 1'b1;
        @(negedge clk);
        checks++; if (fpri !== 1'b1) begin failures++; $display("FAIL enable_latency got=%b exp=1", fpri); end
        cap_frame(-1);
        checks++; if (!cap_ok) begin failures++; $display("FAIL default_timeout got=0 exp=1"); end
        checks++; if (cap_width !== FW) begin failures++; $display("FAIL fpri_width got=%0d exp=%0d", cap_width, FW); end
        for (int i = 1; i <= NBT; i++) begin
            checks++; if (got_b[i] !== exp_byte(i)) begin failures++; $display("FAIL default_byte%0d got=%h exp=%h", i, got_b[i], exp_byte(i)); end
        end
        checks++; if (cap_code_bad || cap_seq_bad) begin failures++; $display("FAIL default_hold got=%b%b exp=00", cap_code_bad, cap_seq_bad); end
        checks++; if (!cap_done_ok) begin failures++; $display("FAIL default_done got=%b exp=1", frame_done); end
    endtask

    task automatic test_gap_period();
        int k;
        bit code_seen;
        k = 0; code_seen = 1'b0;
        while (fpri !== 1'b1 && k < FP) begin
            @(negedge clk); k++;
            if (fpri !== 1'b1 && code !== 1'b0) code_seen = 1'b1;
        end
        checks++; if (k !== FP - FW - 32 * NBT) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", k, FP - FW - 32 * NBT); end
        checks++; if (code_seen) begin failures++; $display("FAIL gap_code got=1 exp=0"); end
        cap_frame(-1);
        for (int i = 1; i <= NBT; i++) begin
            checks++; if (got_b[i] !== exp_byte(i)) begin failures++; $display("FAIL second_byte%0d got=%h exp=%h", i, got_b[i], exp_byte(i)); end
        end
    endtask

    task automatic test_random_fields();
        for (int it = 0; it < 4; it++) begin
            for (int i = 3; i <= 22; i++) in_b[i] = 8'($urandom);
            if (it == 0) begin
                in_b[3] = 8'h03; in_b[7] = 8'h34; in_b[8] = 8'h12; in_b[21] = 8'hEF; in_b[22] = 8'hBE;
            end
            do_load();
            cap_frame(-1);
            checks++; if (!cap_ok || !cap_done_ok || cap_code_bad || cap_seq_bad) begin failures++; $display("FAIL rand%0d_frame got=%b%b%b%b exp=1100", it, cap_ok, cap_done_ok, cap_code_bad, cap_seq_bad); end
            for (int i = 1; i <= NBT; i++) begin
                checks++; if (got_b[i] !== exp_byte(i)) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, got_b[i], exp_byte(i)); end
            end
        end
    endtask

    task automatic test_load_at_rise();
        logic [7:0] old_wm;
        // Positioned at t0+32*NBT; next rise is at FPRI-rise + FP
        repeat (FP - 1 - FW - 32 * NBT) @(negedge clk);
        old_wm = st_b[3];
        in_b[3] = old_wm ^ 8'h5A;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        cap_frame(-1);
        checks++; if (got_b[3] !== old_wm) begin failures++; $display("FAIL rise_load_cur got=%h exp=%h", got_b[3], old_wm); end
        for (int i = 3; i <= 22; i++) st_b[i] = in_b[i];
        cap_frame(-1);
        checks++; if (got_b[3] !== st_b[3]) begin failures++; $display("FAIL rise_load_next got=%h exp=%h", got_b[3], st_b[3]); end
    endtask

    task automatic test_ramp();
        for (int i = 3; i <= 22; i++) in_b[i] = 8'(i - 2);
        do_load();
        cap_frame(-1);
        checks++; if (!cap_done_ok) begin failures++; $display("FAIL ramp_done got=%b exp=1", frame_done); end
        for (int i = 1; i <= NBT; i++) begin
            checks++; if (got_b[i] !== exp_byte(i)) begin failures++; $display("FAIL ramp_byte%0d got=%h exp=%h", i, got_b[i], exp_byte(i)); end
        end
    endtask

    task automatic test_enable_drop();
        bit extra;
        extra = 1'b0;
        cap_frame(50);
        checks++; if (!cap_ok || !cap_done_ok || cap_seq_bad) begin failures++; $display("FAIL drop_frame got=%b%b%b exp=110", cap_ok, cap_done_ok, cap_seq_bad); end
        checks++; if (got_b[NBT] !== exp_byte(NBT)) begin failures++; $display("FAIL drop_last got=%h exp=%h", got_b[NBT], exp_byte(NBT)); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", frame_done); end
        repeat (FP + 20) begin
            @(negedge clk);
            if (fpri !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        checks++; if (extra) begin failures++; $display("FAIL drop_no_fpri got=1 exp=0"); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        repeat (FW + 2) @(negedge clk);
        checks++; if (code !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b%b exp=11", code, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fpri !== 1'b0) begin failures++; $display("FAIL mid_rst_fpri got=%b exp=0", fpri); end
        checks++; if (code !== 1'b0) begin failures++; $display("FAIL mid_rst_code got=%b exp=0", code); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        for (int i = 3; i <= 22; i++) st_b[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cap_frame(-1);
        checks++; if (!cap_ok || !cap_done_ok || cap_code_bad || cap_seq_bad || cap_width !== FW) begin failures++; $display("FAIL mid_restart got=%b%b%b%b w=%0d exp=1100 w=%0d", cap_ok, cap_done_ok, cap_code_bad, cap_seq_bad, cap_width, FW); end
        for (int i = 1; i <= NBT; i++) begin
            checks++; if (got_b[i] !== exp_byte(i)) begin failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, got_b[i], exp_byte(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_gap_period();
        test_random_fields();
        test_load_at_rise();
        test_ramp();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_encode.md
# ctrl_encode

Serial control-word encoder for the DDC control link: builds the 22-byte control frame (header AA/55 plus mode, code and phase fields) and transmits it as a frame pulse `FPRI` and a serial `code` line. It sits directly upstream of the receive-side frame decoder, on the controller/test FPGA or in loopback. Fields are loaded through a staging register, snapshotted at each frame start, and sent once per frame period.

## Interface
Parameters:
- `FPRI_WIDTH`, 100: FPRI high time in `glb_100M` cycles; legal range ≥ 4.
- `FRAME_PERIOD`, 10000: cycles from one FPRI rise to the next; must be ≥ `FPRI_WIDTH` + 4·8·NBYTES + 2100.

Ports (one clock; reset is asynchronous and active-low):
- `glb_100M` in 1: 100 MHz clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: frame generation enable.
- `cfg_load` in 1: one-cycle strobe; copies all field inputs into staging.
- `work_mode`, `ver_code`, `wave_code`, `fre_code`, `hor1_code`, `hor2_code`, `hor3_code`, `pulse_mode`, `monitor_addr`, `monitor_mode` in 8 each: byte fields.
- `pri_code`, `hor_phase_R`, `ver_phase_R`, `hor_phase_T`, `ver_phase_T` in 16 each: word fields.
- `FPRI` out 1: frame pulse.
- `code` out 1: serial data.
- `busy` out 1: high from FPRI rise to the end of the last bit.
- `frame_done` out 1: one-cycle pulse after the last bit.

## Operation
- Byte order, indices 1..22: AA, 55, work_mode, ver_code, wave_code, fre_code, pri_code[7:0], pri_code[15:8], hor1, hor2, hor3, pulse_mode, monitor_addr, monitor_mode, hor_phase_R lo/hi, ver_phase_R lo/hi, hor_phase_T lo/hi, ver_phase_T lo/hi.
- Each byte is sent MSB first. Each bit is held for exactly 4 cycles (localparam `BIT_CLKS` = 4, fixed by the decoder).
- Staging: `cfg_load` writes all inputs into the staging registers on that edge. Staging resets to 0.
- Snapshot: on the cycle FPRI rises, staging is copied to the frame buffer. A `cfg_load` in that same cycle lands in the next frame.
- FSM:
  - IDLE: `enable` = 1 → SYNC (FPRI = 1, snapshot taken).
  - SYNC: after `FPRI_WIDTH` cycles → SHIFT (FPRI = 0).
  - SHIFT: after 176 bits (704 cycles), or 184 with the checksum → GAP, with `frame_done` pulsed.
  - GAP: when the period counter reaches `FRAME_PERIOD` − 1 → SYNC if `enable`, else IDLE.
- The period counter is 16 bits, reset at FPRI rise, and saturates.
- `enable` dropping mid-frame: the current frame completes, then the FSM goes to IDLE. No truncated frames are ever sent.
- `code` = 0 in IDLE, SYNC and GAP.

## Timing
- Reset values: `FPRI` = 0, `code` = 0, `busy` = 0, `frame_done` = 0, FSM = IDLE, all counters 0.
- `FPRI` and `code` are registered outputs.
- Latency: `enable` high at edge k → FPRI = 1 from k+1. The first FPRI rise occurs within 1 cycle of enable.
- Let t0 be the first cycle with FPRI = 0. Bit n (0..175) is driven on cycles t0+4n .. t0+4n+3.
- `frame_done` is high at t0+704 (t0+736 with the checksum). `busy` is low from that same cycle.
- Consecutive FPRI rises are exactly `FRAME_PERIOD` cycles apart while `enable` stays high.
- Async reset mid-frame: outputs clear immediately. After release, operation restarts from IDLE and the frame buffer is reloaded at the next snapshot.

## Configuration
- `CTRL_ENC_CHKSUM_EN`:
  - Defined: a 23rd byte follows byte 22. It is the XOR of bytes 3..22, sent MSB first. SHIFT lasts 184 bits. The decoder ignores byte 23 (default branch).
  - Undefined: exactly 22 bytes are sent and no checksum logic is built.

## Structure
- Package `ctrl_link_pkg`:
  - `HDR1` = 8'hAA, `HDR2` = 8'h55.
  - `NBYTES` = 22, `BIT_CLKS` = 4.
  - Byte-index constants for each field.
  - FSM state enum.
- The decoder side imports the same package.
- One sub-module, `ctrl_byte_ser`: an 8-bit PISO that takes a byte plus a load strobe, emits MSB first at 4 cycles per bit, and pulses `byte_done`. The top module holds the FSM, staging, snapshot, byte-index mux and period counter.

## Test plan
- Reset, `enable` = 1, default fields: FPRI high 100 cycles. After the fall, the first 16 bits are 1010_1010_0101_0101, each held 4 cycles, and `code` = 0 afterwards.
- `cfg_load` with work_mode = 8'h03, pri_code = 16'h1234, ver_phase_T = 16'hBEEF: the loopback decoder reports 03, 1234, BEEF, `flag` = 0 and hor_code = hor3.
- `cfg_load` at the exact FPRI-rise cycle with new work_mode: the current frame still carries the old value and the next frame carries the new one.
- `enable` dropped at bit 50: the frame finishes all 176 bits, `frame_done` pulses, and no further FPRI follows.
- `rst_n` asserted mid-SHIFT: FPRI, `code` and `busy` go to 0 in the same cycle. After release with `enable` = 1, a clean frame starts.
- `CTRL_ENC_CHKSUM_EN` defined, fields 01..14h in bytes 3..22: byte 23 equals the XOR of those bytes, `frame_done` pulses at t0+736, and the decoder fields are unchanged.
